// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter. It shares one synchronous SRAM port between the CPU
// bus slave and the video line-fetch engine. Video wins until a burst limit is hit.
module vram_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_start,
  input  logic [AW-1:0] vid_base,
  input  logic [7:0]    vid_len,
  output logic          vid_busy,
  output logic          vid_wvalid,
  output logic [7:0]    vid_waddr,
  output logic [DW-1:0] vid_wdata,
  output logic          vid_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic [AW-1:0] base;
  logic [7:0]    len;
  logic [7:0]    issued;
  logic [BW-1:0] burst_cnt;
  logic          cpu_rd_q;
  logic [DW-1:0] rdata_q;

  logic cpu_eligible;
  logic burst_full;
  logic vid_slot;
  logic cpu_slot;

  // SRAM latency is one cycle, so a CPU access is in flight exactly during its ack cycle.
  assign cpu_eligible = cpu_req & ~cpu_ack;
  assign burst_full   = (burst_cnt == BW'(MAX_BURST));

  // NOTE: slots are gated by rst so the SRAM port goes quiet the moment reset asserts.
  assign vid_slot = rst & vid_busy & (issued < len) & ~(burst_full & cpu_eligible);
  assign cpu_slot = rst & ~vid_slot & cpu_eligible;

  assign mem_en    = vid_slot | cpu_slot;
  assign mem_we    = cpu_slot & cpu_we;
  assign mem_addr  = vid_slot ? base + AW'(issued) : (cpu_slot ? cpu_addr : '0);
  assign mem_wdata = (cpu_slot & cpu_we) ? cpu_wdata : '0;

  assign vid_wdata = vid_wvalid ? mem_rdata : '0;
  assign cpu_rdata = (cpu_ack & cpu_rd_q) ? mem_rdata : rdata_q;

  // NOTE: all state uses non-blocking assignments; later assignments in this block win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base       <= '0;
      len        <= '0;
      issued     <= '0;
      burst_cnt  <= '0;
      cpu_rd_q   <= 1'b0;
      rdata_q    <= '0;
      cpu_ack    <= 1'b0;
      vid_busy   <= 1'b0;
      vid_wvalid <= 1'b0;
      vid_waddr  <= '0;
      vid_done   <= 1'b0;
    end else begin
      vid_wvalid <= vid_slot;
      vid_done   <= 1'b0;
      cpu_ack    <= cpu_slot;
      cpu_rd_q   <= cpu_slot & ~cpu_we;

      if (cpu_ack && cpu_rd_q) rdata_q <= mem_rdata;

      if (vid_slot) begin
        issued    <= issued + 8'd1;
        vid_waddr <= issued;
        if (issued == len - 8'd1) vid_done <= 1'b1;
        if (!burst_full) burst_cnt <= burst_cnt + BW'(1);
      end else begin
        burst_cnt <= '0;
      end

      if (vid_done) vid_busy <= 1'b0;

      // A start while busy (including the done cycle) is dropped.
      if (vid_start && !vid_busy) begin
        if (vid_len != 8'd0) begin
          vid_busy <= 1'b1;
          base     <= vid_base;
          len      <= vid_len;
          issued   <= '0;
        end else begin
          vid_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: an SRAM model answers reads with an
// address-derived pattern (or written data); every cycle is logged at negedge.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        vid_start;
  logic [15:0] vid_base;
  logic [7:0]  vid_len;
  logic        vid_busy;
  logic        vid_wvalid;
  logic [7:0]  vid_waddr;
  logic [31:0] vid_wdata;
  logic        vid_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  vram_arbiter #(.AW(16), .DW(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_start(vid_start), .vid_base(vid_base), .vid_len(vid_len),
    .vid_busy(vid_busy), .vid_wvalid(vid_wvalid), .vid_waddr(vid_waddr),
    .vid_wdata(vid_wdata), .vid_done(vid_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] pattern(input logic [15:0] a);
    return {~a, a};
  endfunction

  // SRAM model with one-cycle read latency.
  logic [31:0] wr_mem [logic [15:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) wr_mem[mem_addr] = mem_wdata;
      else mem_rdata <= wr_mem.exists(mem_addr) ? wr_mem[mem_addr] : pattern(mem_addr);
    end
  end

  typedef struct {
    logic        en, we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] vd;
    logic        done, ack;
    logic [31:0] rd;
    logic        busy;
  } rec_t;

  rec_t log_q[$];
  bit   logging = 0;

  always @(negedge clk) begin
    if (logging) begin
      rec_t r;
      r.en = mem_en; r.we = mem_we; r.addr = mem_addr; r.wd = mem_wdata;
      r.wv = vid_wvalid; r.wa = vid_waddr; r.vd = vid_wdata;
      r.done = vid_done; r.ack = cpu_ack; r.rd = cpu_rdata; r.busy = vid_busy;
      log_q.push_back(r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_log();
    log_q.delete();
    logging = 1;
  endtask

  task automatic start_line(input logic [15:0] b, input logic [7:0] l);
    vid_start = 1'b1; vid_base = b; vid_len = l;
    tick();
    vid_start = 1'b0;
  endtask

  function automatic int count_en();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].en) c++;
    return c;
  endfunction

  function automatic int count_wv();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].wv) c++;
    return c;
  endfunction

  function automatic int count_done();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].done) c++;
    return c;
  endfunction

  // Holds the request until acked (bounded), then drops it.
  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [31:0] d);
    bit got = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cpu_ack) begin got = 1; break; end
    end
    cpu_req = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL cpu_ack_timeout addr=%h got no ack want ack within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({vid_busy, vid_wvalid, vid_done, cpu_ack, mem_en, mem_we} !== 6'b0 ||
        mem_addr !== 16'h0 || vid_waddr !== 8'h0 || cpu_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b wv=%b done=%b ack=%b en=%b addr=%h want all 0",
               vid_busy, vid_wvalid, vid_done, cpu_ack, mem_en, mem_addr);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_video_only();
    start_log();
    start_line(16'h0200, 8'd4);
    repeat (10) tick();
    logging = 0;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (log_q[i].en !== 1'b1 || log_q[i].we !== 1'b0 || log_q[i].addr !== 16'h0200 + 16'(i - 1)) begin
        n_bad++;
        $display("FAIL vid_addr[%0d] got en=%b we=%b addr=%h want en=1 we=0 addr=%h",
                 i, log_q[i].en, log_q[i].we, log_q[i].addr, 16'h0200 + 16'(i - 1));
      end
    end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++;
      if (log_q[i].wv !== 1'b1 || log_q[i].wa !== 8'(i - 2) || log_q[i].vd !== pattern(16'h0200 + 16'(i - 2))) begin
        n_bad++;
        $display("FAIL vid_write[%0d] got wv=%b waddr=%0d data=%h want wv=1 waddr=%0d data=%h",
                 i, log_q[i].wv, log_q[i].wa, log_q[i].vd, i - 2, pattern(16'h0200 + 16'(i - 2)));
      end
    end
    n_cmp++;
    if (log_q[5].done !== 1'b1 || log_q[5].busy !== 1'b1 || log_q[6].busy !== 1'b0) begin
      n_bad++;
      $display("FAIL vid_done_busy got done=%b busy=%b busy_next=%b want 1 1 0",
               log_q[5].done, log_q[5].busy, log_q[6].busy);
    end
    n_cmp++;
    if (log_q[1].busy !== 1'b1 || log_q[0].busy !== 1'b0) begin
      n_bad++;
      $display("FAIL vid_busy_rise got start=%b next=%b want 0 1", log_q[0].busy, log_q[1].busy);
    end
    n_cmp++;
    if (count_en() != 4 || count_wv() != 4 || count_done() != 1) begin
      n_bad++;
      $display("FAIL vid_counts got en=%0d wv=%0d done=%0d want 4 4 1", count_en(), count_wv(), count_done());
    end
  endtask

  task automatic test_cpu_only();
    int acks = 0;
    start_log();
    cpu_access(1'b1, 16'h0010, 32'hDEAD_BEEF);
    tick();
    cpu_access(1'b0, 16'h0010, 32'h0);
    repeat (2) tick();
    logging = 0;
    n_cmp++;
    if (log_q[0].en !== 1'b1 || log_q[0].we !== 1'b1 || log_q[0].addr !== 16'h0010 || log_q[0].wd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL cpu_write_slot got en=%b we=%b addr=%h wdata=%h want 1 1 0010 deadbeef",
               log_q[0].en, log_q[0].we, log_q[0].addr, log_q[0].wd);
    end
    for (int i = 1; i < log_q.size(); i++) begin
      if (log_q[i].ack) begin
        acks++;
        n_cmp++;
        if (log_q[i].en !== 1'b0 || log_q[i - 1].en !== 1'b1) begin
          n_bad++;
          $display("FAIL cpu_ack_timing[%0d] got en_in_ack=%b en_before=%b want 0 1",
                   i, log_q[i].en, log_q[i - 1].en);
        end
      end
    end
    n_cmp++;
    if (acks != 2 || log_q[log_q.size() - 1].ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_ack_count got %0d want 2", acks);
    end
    n_cmp++;
    if (log_q[2].en !== 1'b1 || log_q[2].we !== 1'b0 || log_q[3].ack !== 1'b1 || log_q[3].rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL cpu_read got slot_en=%b we=%b ack=%b rdata=%h want 1 0 1 deadbeef",
               log_q[2].en, log_q[2].we, log_q[3].ack, log_q[3].rd);
    end
    n_cmp++;
    if (log_q[4].rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL cpu_rdata_hold got %h want deadbeef", log_q[4].rd);
    end
  endtask

  task automatic test_contention();
    int k = 0;
    start_log();
    start_line(16'h1000, 8'd20);
    cpu_access(1'b0, 16'h0020, 32'h0);
    repeat (25) tick();
    logging = 0;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (log_q[i].en !== 1'b1 || log_q[i].we !== 1'b0 || log_q[i].addr !== 16'h1000 + 16'(i - 1)) begin
        n_bad++;
        $display("FAIL burst_addr[%0d] got en=%b addr=%h want en=1 addr=%h",
                 i, log_q[i].en, log_q[i].addr, 16'h1000 + 16'(i - 1));
      end
    end
    n_cmp++;
    if (log_q[9].en !== 1'b1 || log_q[9].we !== 1'b0 || log_q[9].addr !== 16'h0020) begin
      n_bad++;
      $display("FAIL cpu_slot_after_burst got en=%b we=%b addr=%h want 1 0 0020",
               log_q[9].en, log_q[9].we, log_q[9].addr);
    end
    n_cmp++;
    if (log_q[10].ack !== 1'b1 || log_q[10].rd !== pattern(16'h0020) || log_q[10].wv !== 1'b0 ||
        log_q[10].addr !== 16'h1008) begin
      n_bad++;
      $display("FAIL cpu_ack_resume got ack=%b rdata=%h wv=%b addr=%h want 1 %h 0 1008",
               log_q[10].ack, log_q[10].rd, log_q[10].wv, log_q[10].addr, pattern(16'h0020));
    end
    foreach (log_q[i]) begin
      if (log_q[i].wv) begin
        n_cmp++;
        if (log_q[i].wa !== 8'(k) || log_q[i].vd !== pattern(16'h1000 + 16'(k))) begin
          n_bad++;
          $display("FAIL line_order[%0d] got waddr=%0d data=%h want %0d %h",
                   k, log_q[i].wa, log_q[i].vd, k, pattern(16'h1000 + 16'(k)));
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 20 || count_done() != 1 || count_en() != 21) begin
      n_bad++;
      $display("FAIL contention_counts got wv=%0d done=%0d en=%0d want 20 1 21", k, count_done(), count_en());
    end
  endtask

  task automatic test_wrap_zero();
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    start_log();
    start_line(16'hFFFE, 8'd4);
    repeat (8) tick();
    logging = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (log_q[i + 1].addr !== exp_a[i] || log_q[i + 1].en !== 1'b1 || log_q[i + 2].vd !== pattern(exp_a[i])) begin
        n_bad++;
        $display("FAIL wrap_addr[%0d] got addr=%h data=%h want %h %h",
                 i, log_q[i + 1].addr, log_q[i + 2].vd, exp_a[i], pattern(exp_a[i]));
      end
    end
    start_log();
    start_line(16'h0700, 8'd0);
    repeat (4) tick();
    logging = 0;
    n_cmp++;
    if (log_q[1].done !== 1'b1 || count_done() != 1 || count_en() != 0 || log_q[1].busy !== 1'b0 ||
        log_q[2].busy !== 1'b0 || count_wv() != 0) begin
      n_bad++;
      $display("FAIL zero_len got done=%b ndone=%0d en=%0d busy=%b want 1 1 0 0",
               log_q[1].done, count_done(), count_en(), log_q[1].busy);
    end
  endtask

  task automatic test_start_while_busy();
    int bad_addr = 0;
    start_log();
    start_line(16'h0300, 8'd8);
    tick();
    start_line(16'h0400, 8'd4);
    repeat (14) tick();
    logging = 0;
    foreach (log_q[i]) if (log_q[i].en && (log_q[i].addr < 16'h0300 || log_q[i].addr > 16'h0307)) bad_addr++;
    n_cmp++;
    if (count_en() != 8 || bad_addr != 0 || count_done() != 1 || count_wv() != 8) begin
      n_bad++;
      $display("FAIL start_while_busy got en=%0d stray=%0d done=%0d wv=%0d want 8 0 1 8",
               count_en(), bad_addr, count_done(), count_wv());
    end
  endtask

  task automatic test_back_to_back();
    // len=2: slots in cycles 1-2, done in cycle 3; a start in that cycle is dropped.
    start_log();
    start_line(16'h0500, 8'd2);
    repeat (2) tick();
    start_line(16'h0600, 8'd2);
    repeat (6) tick();
    logging = 0;
    n_cmp++;
    if (log_q[3].done !== 1'b1 || log_q[3].busy !== 1'b1 || count_en() != 2 || count_done() != 1 ||
        log_q[4].busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_on_done got done=%b busy=%b en=%0d ndone=%0d want 1 1 2 1",
               log_q[3].done, log_q[3].busy, count_en(), count_done());
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    start_line(16'h0100, 8'd16);
    for (int k = 0; k < 30 && seen < 5; k++) begin
      if (vid_wvalid) seen++;
      if (seen < 5) tick();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({vid_busy, vid_wvalid, vid_done, cpu_ack, mem_en, mem_we} !== 6'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 32'h0 || vid_waddr !== 8'h0 || vid_wdata !== 32'h0 || cpu_rdata !== 32'h0 || seen != 5) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got busy=%b wv=%b en=%b addr=%h waddr=%0d rdata=%h seen=%0d want all 0 seen=5",
               vid_busy, vid_wvalid, mem_en, mem_addr, vid_waddr, cpu_rdata, seen);
    end
    repeat (2) tick();
    rst = 1'b1;
    start_log();
    repeat (30) tick();
    logging = 0;
    n_cmp++;
    if (count_wv() != 0 || count_done() != 0 || count_en() != 0) begin
      n_bad++;
      $display("FAIL post_reset_quiet got wv=%0d done=%0d en=%0d want 0 0 0", count_wv(), count_done(), count_en());
    end
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_start = 0; vid_base = '0; vid_len = '0; mem_rdata = '0;
    test_reset();
    test_video_only();
    tick();
    test_cpu_only();
    tick();
    test_contention();
    tick();
    test_wrap_zero();
    tick();
    test_start_while_busy();
    tick();
    test_back_to_back();
    tick();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
